// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access stage load/store unit.
// Sits between the EX/MEM and MEM/WB pipeline registers. It turns a load or
// store into a req/ack data-memory transaction and stalls the pipeline while
// the transaction is outstanding. It also produces the write-back value and
// the register-write enable for MEM/WB.
//
// Optional feature: define MEM_TIMEOUT_EN to enable the WAIT timeout. After
// TIMEOUT_CYCLES WAIT cycles without mem_ack, the unit pulses bus_err and
// retires the instruction with no register write.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   mem_read_in, mem_write_in   EX/MEM load / store flags (both set = store)
//   size_in, sign_ext_in        access size (00 B, 01 H, 1x W), load extension
//   alu_result_in               ALU result / effective address
//   store_data_in               store source value
//   IP_write_in                 EX/MEM register write enable
//   mem_req/we/addr/be/wdata    registered data-memory request bus
//   mem_ack, mem_rdata          one-cycle acknowledge with read data
//   stall                       hold the pipeline
//   data_out, IP_write_out      to MEM/WB
//   misalign_err                current access is misaligned (combinational)
//   bus_err                     one-cycle timeout pulse
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  size_in,
  input  logic        sign_ext_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        IP_write_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] data_out,
  output logic        IP_write_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mem_op;
  logic        misaligned;
  logic        launch;

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane,
                                          input logic st);
    logic [3:0] be;
    be = 4'b1111;
    if (st) begin
      case (sz)
        2'b00:   be = 4'b0001 << lane;
        2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] sd);
    logic [31:0] wd;
    case (sz)
      2'b00:   wd = {4{sd[7:0]}};
      2'b01:   wd = {2{sd[15:0]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic sx);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    b   = 8'(w >> {lane, 3'b000});
    h   = lane[1] ? w[31:16] : w[15:0];
    b_s = b;
    h_s = h;
    case (sz)
      2'b00:   ext = sx ? 32'(b_s) : {24'd0, b};
      2'b01:   ext = sx ? 32'(h_s) : {16'd0, h};
      default: ext = w;
    endcase
    return ext;
  endfunction

  assign mem_op = mem_read_in | mem_write_in;

  always_comb begin
    misaligned = 1'b0;
    case (size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_in[0];
      default: misaligned = |alu_result_in[1:0];
    endcase
  end

  assign misalign_err = mem_op & misaligned;
  assign launch       = (state == IDLE) & mem_op & ~misaligned;
  assign stall        = launch | (state == WAIT);

  // EX/MEM inputs are held by the stall, so DONE can still decode the
  // instruction that launched the transaction.
  always_comb begin
    data_out     = alu_result_in;
    IP_write_out = IP_write_in;
    if (state == DONE) begin
      if (err_q) begin
        data_out     = 32'd0;
        IP_write_out = 1'b0;
      end else if (!mem_write_in) begin
        data_out = load_fmt(rdata_q, size_in, alu_result_in[1:0], sign_ext_in);
      end
    end else if (state == IDLE && misalign_err) begin
      data_out     = 32'd0;
      IP_write_out = 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = &{1'b0, 8'(TIMEOUT_CYCLES)};
  assign err_q          = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rdata_q   <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt   <= 8'd0;
      err_q     <= 1'b0;
      bus_err   <= 1'b0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (launch) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write_in;
            mem_addr  <= {alu_result_in[31:2], 2'b00};
            mem_be    <= store_be(size_in, alu_result_in[1:0], mem_write_in);
            mem_wdata <= store_wdata(size_in, store_data_in);
            state     <= WAIT;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt   <= 8'd0;
            err_q     <= 1'b0;
`endif
          end
        end
        WAIT: begin
          // An ack on the limit cycle takes priority over the timeout.
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            err_q   <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in;
  logic [1:0]  size_in;
  logic        sign_ext_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        IP_write_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] data_out;
  logic        IP_write_out, misalign_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .size_in(size_in), .sign_ext_in(sign_ext_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .IP_write_in(IP_write_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .data_out(data_out), .IP_write_out(IP_write_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    size_in       = 2'b00;
    sign_ext_in   = 1'b0;
    alu_result_in = 32'd0;
    store_data_in = 32'd0;
    IP_write_in   = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'd0;
  endtask

  // Runs one aligned transaction from an IDLE cycle through DONE; ack arrives
  // in WAIT cycle ack_n. Leaves the bench one cycle after DONE with inputs cleared.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sx, input logic [31:0] addr, input logic [31:0] sd,
                     input logic ipw, input logic [31:0] rdata, input int ack_n,
                     input logic [31:0] exp_addr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_dout);
    mem_read_in = rd; mem_write_in = wr; size_in = sz; sign_ext_in = sx;
    alu_result_in = addr; store_data_in = sd; IP_write_in = ipw;
    @(negedge clk);
    chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
    chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
    for (int k = 1; k <= ack_n; k++) begin
      next_cycle();
      if (k == ack_n) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      chk({tag, ".wait_stall"}, 32'(stall), 32'd1);
      chk({tag, ".wait_req"}, 32'(mem_req), 32'd1);
      if (k == 1) begin
        chk({tag, ".addr"}, mem_addr, exp_addr);
        chk({tag, ".be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, ".we"}, 32'(mem_we), 32'(wr));
        if (wr) chk({tag, ".wdata"}, mem_wdata, exp_wdata);
      end
    end
    next_cycle();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    @(negedge clk);
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".done_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".done_data"}, data_out, exp_dout);
    chk({tag, ".done_ipw"}, 32'(IP_write_out), 32'(ipw));
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #2;
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // ALU pass-through
    alu_result_in = 32'h1234_5678; IP_write_in = 1'b1;
    @(negedge clk);
    chk("alu.stall", 32'(stall), 32'd0);
    chk("alu.data", data_out, 32'h1234_5678);
    chk("alu.ipw", 32'(IP_write_out), 32'd1);
    chk("alu.misalign", 32'(misalign_err), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("alu.req", 32'(mem_req), 32'd0);
    // ack outside WAIT is ignored
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack.req", 32'(mem_req), 32'd0);
    chk("stray_ack.stall", 32'(stall), 32'd0);
    chk("stray_ack.data", data_out, 32'h1234_5678);
    next_cycle();
    clear_inputs();

    // Word load, ack in 3rd WAIT cycle: stall for 4 cycles
    txn("ldw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 1'b1,
        32'hCAFE_F00D, 3, 32'h0000_0100, 4'b1111, 32'd0, 32'hCAFE_F00D);

    // Byte loads at lane 3, signed then unsigned, minimum latency
    txn("ldb_s", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'd0, 1'b1,
        32'h8012_3456, 1, 32'h0000_0200, 4'b1111, 32'd0, 32'hFFFF_FF80);
    txn("ldb_u", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'd0, 1'b1,
        32'h8012_3456, 1, 32'h0000_0200, 4'b1111, 32'd0, 32'h0000_0080);

    // Signed half load from upper half
    txn("ldh_s", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0306, 32'd0, 1'b1,
        32'h9ABC_1234, 2, 32'h0000_0304, 4'b1111, 32'd0, 32'hFFFF_9ABC);

    // Half store at 0x42
    txn("sth", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_BEEF, 1'b0,
        32'd0, 2, 32'h0000_0040, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0042);

    // Read and write both set: byte store at lane 1
    txn("stb_rw", 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0081, 32'h1234_56A5, 1'b0,
        32'h5555_5555, 1, 32'h0000_0080, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0081);

    // Misaligned word load
    mem_read_in = 1'b1; size_in = 2'b10; alu_result_in = 32'h0000_0101; IP_write_in = 1'b1;
    @(negedge clk);
    chk("misw.err", 32'(misalign_err), 32'd1);
    chk("misw.stall", 32'(stall), 32'd0);
    chk("misw.ipw", 32'(IP_write_out), 32'd0);
    chk("misw.data", data_out, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("misw.req", 32'(mem_req), 32'd0);
    // Misaligned half
    size_in = 2'b01; alu_result_in = 32'h0000_0043;
    #1;
    chk("mish.err", 32'(misalign_err), 32'd1);
    next_cycle();
    clear_inputs();

    // Reset during WAIT aborts the transaction immediately
    mem_read_in = 1'b1; size_in = 2'b10; alu_result_in = 32'h0000_0010; IP_write_in = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rstw.req_before", 32'(mem_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstw.req", 32'(mem_req), 32'd0);
    clear_inputs();
    #1;
    chk("rstw.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rstw.req_after", 32'(mem_req), 32'd0);
    chk("rstw.stall_after", 32'(stall), 32'd0);
    next_cycle();

`ifdef MEM_TIMEOUT_EN
    // No ack: bus error after 4 WAIT cycles, instruction retires with no write
    mem_read_in = 1'b1; size_in = 2'b10; alu_result_in = 32'h0000_0020; IP_write_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("tmo.wait_stall", 32'(stall), 32'd1);
      chk("tmo.wait_req", 32'(mem_req), 32'd1);
      chk("tmo.wait_bus_err", 32'(bus_err), 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("tmo.bus_err", 32'(bus_err), 32'd1);
    chk("tmo.req", 32'(mem_req), 32'd0);
    chk("tmo.stall", 32'(stall), 32'd0);
    chk("tmo.ipw", 32'(IP_write_out), 32'd0);
    chk("tmo.data", data_out, 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("tmo.bus_err_pulse", 32'(bus_err), 32'd0);
    next_cycle();
    // Ack on the limit cycle wins
    txn("tmo_ack", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'd0, 1'b1,
        32'h0BAD_F00D, 4, 32'h0000_0024, 4'b1111, 32'd0, 32'h0BAD_F00D);
`else
    // Without the timeout, a long wait simply persists until ack
    txn("long", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'd0, 1'b1,
        32'h0BAD_F00D, 6, 32'h0000_0024, 4'b1111, 32'd0, 32'h0BAD_F00D);
    chk("long.bus_err", 32'(bus_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
